// File: rtl/dds_phase_accum.sv
// Phase accumulator with a prescaled tick, a double-buffered nibble-loaded tuning word and a
// registered LUT read port. Define DDS_QUARTER_WAVE_EN for quarter-wave LUT addressing.
module dds_phase_accum #(
    parameter int unsigned ACC_W = 16,
    parameter int unsigned AW    = 4,
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    input  logic [3:0]       tw_nib,
    input  logic             tw_valid,
    input  logic             tw_start,
    output logic             tw_ready,
    output logic [AW-1:0]    lut_ra,
    output logic             lut_re,
    output logic             wrap,
    output logic             sign
);

    localparam int unsigned NIBS = ACC_W / 4;
    localparam int unsigned NCW  = $clog2(NIBS + 1);

    typedef enum logic [1:0] {StIdle, StShift, StPend} load_st_e;

    load_st_e         state_q, state_d;
    logic [NCW-1:0]   nib_cnt_q, nib_cnt_d;
    logic [ACC_W-1:0] shadow_q, shadow_d;
    logic [ACC_W-1:0] active_q, active_d;
    logic [ACC_W-1:0] phase_q;
    logic [DIV_W-1:0] cnt_q;
    logic             tick;
    logic [ACC_W:0]   sum;
    logic [AW-1:0]    ra_next;
    logic             sign_next;

    // >= rather than == so that lowering div mid-count ticks immediately
    assign tick = en && (cnt_q >= div);
    assign sum  = {1'b0, phase_q} + {1'b0, active_q};

`ifdef DDS_QUARTER_WAVE_EN
    logic [1:0]    quad;
    logic [AW-1:0] qa;

    assign quad      = sum[ACC_W-1:ACC_W-2];
    assign qa        = sum[ACC_W-3 -: AW];
    // Odd quadrants walk the quarter-sine table backwards
    assign ra_next   = quad[0] ? ~qa : qa;
    assign sign_next = quad[1];
`else
    assign ra_next   = sum[ACC_W-1 -: AW];
    assign sign_next = 1'b0;
`endif

    assign tw_ready = rst || (state_q != StPend);

    always_comb begin
        state_d   = state_q;
        nib_cnt_d = nib_cnt_q;
        shadow_d  = shadow_q;
        active_d  = active_q;
        if (tw_start) begin
            // Restart discards any pending commit; a concurrent nibble becomes nibble 0
            nib_cnt_d = '0;
            state_d   = StIdle;
            if (tw_valid) begin
                shadow_d  = {shadow_q[ACC_W-5:0], tw_nib};
                nib_cnt_d = NCW'(1);
                state_d   = StShift;
            end
        end else begin
            case (state_q)
                StIdle, StShift: begin
                    if (tw_valid) begin
                        shadow_d = {shadow_q[ACC_W-5:0], tw_nib};
                        if (nib_cnt_q == NCW'(NIBS - 1)) begin
                            nib_cnt_d = '0;
                            state_d   = StPend;
                        end else begin
                            nib_cnt_d = nib_cnt_q + 1'b1;
                            state_d   = StShift;
                        end
                    end
                end
                StPend: begin
                    if (tick) begin
                        active_d = shadow_q;
                        state_d  = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            nib_cnt_q <= '0;
            shadow_q  <= '0;
            active_q  <= '0;
            phase_q   <= '0;
            cnt_q     <= '0;
            lut_ra    <= '0;
            lut_re    <= 1'b0;
            wrap      <= 1'b0;
            sign      <= 1'b0;
        end else begin
            state_q   <= state_d;
            nib_cnt_q <= nib_cnt_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            if (tick) begin
                cnt_q   <= '0;
                phase_q <= sum[ACC_W-1:0];
                lut_ra  <= ra_next;
                sign    <= sign_next;
                lut_re  <= 1'b1;
                wrap    <= sum[ACC_W];
            end else begin
                if (en) begin
                    cnt_q <= cnt_q + 1'b1;
                end
                lut_re <= 1'b0;
                wrap   <= 1'b0;
            end
        end
    end

endmodule
